// File: rtl/udma_tx_ch_arbiter.sv
// Round-robin arbiter sharing one L2 read port among the uDMA TX channels.
// Tracks outstanding reads in order and steers aligned read data back
// to the channel that issued each request.
module udma_tx_ch_arbiter #(
  parameter int N_CH      = 4,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [N_CH-1:0]      ch_req_i,
  input  logic [N_CH*AW-1:0]   ch_addr_i,
  input  logic [N_CH*2-1:0]    ch_datasize_i,
  output logic [N_CH-1:0]      ch_gnt_o,
  output logic [N_CH-1:0]      ch_valid_o,
  output logic [DW-1:0]        ch_data_o,
  input  logic [N_CH-1:0]      ch_ready_i,
  output logic                 mem_req_o,
  output logic [AW-1:0]        mem_addr_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DW-1:0]        mem_rdata_i
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST) + 1;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    off;
    logic [1:0]    size;
  } trk_t;

  logic [N_CH-1:0][AW-1:0] ch_addr;
  logic [N_CH-1:0][1:0]    ch_size;

  logic [IW-1:0] rr_ptr, lock_sel, rr_sel, sel, rr_idx;
  logic          lock, rr_found;
  logic [CW-1:0] credit, dcnt;
  logic          has_credit, grant, pop, dvalid;
  logic [AW-1:0] sel_addr;

  trk_t          tmem [MAX_OUTST];
  logic [DW-1:0] dmem [MAX_OUTST];
  logic [PW-1:0] t_wr, t_rd, d_wr, d_rd;
  trk_t          head;
  logic [DW-1:0] raw, shifted, aligned;

  assign ch_addr = ch_addr_i;
  assign ch_size = ch_datasize_i;

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      rr_idx = IW'((int'(rr_ptr) + i) % N_CH);
      if (!rr_found && ch_req_i[rr_idx]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
    end
  end

  // A pending, ungranted request keeps its channel until L2 accepts it.
  assign sel        = lock ? lock_sel : rr_sel;
  assign has_credit = credit < CW'(MAX_OUTST);
  assign mem_req_o  = (|ch_req_i) & has_credit;
  assign grant      = mem_req_o & mem_gnt_i;
  assign sel_addr   = ch_addr[sel];
  assign mem_addr_o = mem_req_o ? (sel_addr & ~AW'(3)) : '0;
  assign ch_gnt_o   = grant ? (N_CH'(1) << sel) : '0;

  // Priority pointer and request lock.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_sel <= '0;
    end else if (grant) begin
      rr_ptr <= (sel == IW'(N_CH - 1)) ? '0 : sel + IW'(1);
      lock   <= 1'b0;
    end else if (mem_req_o) begin
      lock     <= 1'b1;
      lock_sel <= sel;
    end
  end

  // Tracking and data FIFO storage (contents need no reset).
  always_ff @(posedge clk_i) begin
    if (grant)        tmem[t_wr] <= '{id: sel, off: sel_addr[1:0], size: ch_size[sel]};
    if (mem_rvalid_i) dmem[d_wr] <= mem_rdata_i;
  end

  // FIFO pointers, data count and outstanding-read credit.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      t_wr   <= '0;
      t_rd   <= '0;
      d_wr   <= '0;
      d_rd   <= '0;
      dcnt   <= '0;
      credit <= '0;
    end else begin
      if (grant)        t_wr <= t_wr + PW'(1);
      if (mem_rvalid_i) d_wr <= d_wr + PW'(1);
      if (pop) begin
        t_rd <= t_rd + PW'(1);
        d_rd <= d_rd + PW'(1);
      end
      case ({mem_rvalid_i, pop})
        2'b10:   dcnt <= dcnt + CW'(1);
        2'b01:   dcnt <= dcnt - CW'(1);
        default: dcnt <= dcnt;
      endcase
      case ({grant, pop})
        2'b10:   credit <= credit + CW'(1);
        2'b01:   credit <= credit - CW'(1);
        default: credit <= credit;
      endcase
    end
  end

  // Delivery: head response goes to its originating channel, strictly in order.
  assign head       = tmem[t_rd];
  assign dvalid     = (dcnt != '0);
  assign pop        = dvalid & ch_ready_i[head.id];
  assign ch_valid_o = dvalid ? (N_CH'(1) << head.id) : '0;

  // Align read data to the requested byte lane and size.
  always_comb begin
    raw     = dmem[d_rd];
    shifted = raw >> {head.off, 3'b000};
    case (head.size)
      2'b00:   aligned = DW'(shifted[7:0]);
      2'b01:   aligned = DW'(shifted[15:0]);
      default: aligned = raw;
    endcase
  end

  assign ch_data_o = dvalid ? aligned : '0;

  // L2 must not return data that was never requested.
  a_rvalid_tracked: assert property (@(posedge clk_i) disable iff (!rstn_i)
    mem_rvalid_i |-> (dcnt < credit));

  // TX channels hold their request until granted.
  a_req_held: assert property (@(posedge clk_i) disable iff (!rstn_i)
    lock |-> ch_req_i[lock_sel]);

endmodule

// File: tb/tb_udma_tx_ch_arbiter.sv
// Directed bench for udma_tx_ch_arbiter: vector table plus multi-cycle sequences.
module tb_udma_tx_ch_arbiter;
  localparam int N = 4, AW = 32, DW = 32, MO = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  req, gnt, vld, rdy;
  logic [N*AW-1:0] addr;
  logic [2*N-1:0]  size;
  logic [DW-1:0] data, rdata;
  logic          mreq, mgnt, rvalid;
  logic [AW-1:0] maddr;

  int errs = 0, checks = 0;

  udma_tx_ch_arbiter #(.N_CH(N), .AW(AW), .DW(DW), .MAX_OUTST(MO)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .ch_req_i(req), .ch_addr_i(addr), .ch_datasize_i(size),
    .ch_gnt_o(gnt), .ch_valid_o(vld), .ch_data_o(data), .ch_ready_i(rdy),
    .mem_req_o(mreq), .mem_addr_o(maddr), .mem_gnt_i(mgnt),
    .mem_rvalid_i(rvalid), .mem_rdata_i(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        mg, rv;
    logic [31:0] rd;
    logic [3:0]  rdy;
    logic [3:0]  e_gnt, e_vld;
    logic [31:0] e_data;
    logic        e_mreq;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t tv[$];

  typedef struct { int id; logic [31:0] d; } resp_t;
  resp_t q[$];

  function automatic vec_t mk(logic [3:0] r, logic [31:0] a, logic [1:0] sz, logic mg,
                              logic rv, logic [31:0] rd, logic [3:0] ry, logic [3:0] eg,
                              logic [3:0] ev, logic [31:0] ed, logic em, logic [31:0] ea);
    vec_t v;
    v.req = r; v.a = a; v.sz = sz; v.mg = mg; v.rv = rv; v.rd = rd; v.rdy = ry;
    v.e_gnt = eg; v.e_vld = ev; v.e_data = ed; v.e_mreq = em; v.e_maddr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    req = '0; mgnt = 0; rvalid = 0; rdata = '0; rdy = '0;
  endtask

  task automatic set_addr(input int ch, input logic [31:0] a);
    addr[ch*AW +: AW] = a;
  endtask

  task automatic do_reset(input string tag);
    rstn = 0;
    idle_in();
    @(negedge clk); @(negedge clk);
    chk({tag, " rst gnt"}, 32'(gnt), 0);
    chk({tag, " rst vld"}, 32'(vld), 0);
    chk({tag, " rst data"}, data, 0);
    chk({tag, " rst mreq"}, 32'(mreq), 0);
    chk({tag, " rst maddr"}, maddr, 0);
    rstn = 1;
    @(negedge clk);
  endtask

  int cnt [N];
  int pend_id;
  logic pend;
  int n_avail;
  resp_t r;

  initial begin
    rstn = 0; idle_in(); addr = '0; size = '0;
    //           req  addr        sz mg rv rdata         rdy  egnt evld edata         emreq emaddr
    tv.push_back(mk(0, 0,          0, 0, 0, 0,            0,   0,   0,   0,            0, 0));
    tv.push_back(mk(1, 32'h1000,   2, 1, 0, 0,            0,   1,   0,   0,            1, 32'h1000));
    tv.push_back(mk(0, 0,          0, 0, 1, 32'hDEADBEEF, 0,   0,   0,   0,            0, 0));
    tv.push_back(mk(0, 0,          0, 0, 0, 0,            0,   0,   1,   32'hDEADBEEF, 0, 0));
    tv.push_back(mk(0, 0,          0, 0, 0, 0,            1,   0,   1,   32'hDEADBEEF, 0, 0));
    tv.push_back(mk(0, 0,          0, 0, 0, 0,            0,   0,   0,   0,            0, 0));
    tv.push_back(mk(1, 32'h2003,   0, 1, 0, 0,            0,   1,   0,   0,            1, 32'h2000));
    tv.push_back(mk(0, 0,          0, 0, 1, 32'hAABBCCDD, 0,   0,   0,   0,            0, 0));
    tv.push_back(mk(0, 0,          0, 0, 0, 0,            1,   0,   1,   32'h000000AA, 0, 0));
    tv.push_back(mk(1, 32'h2002,   1, 1, 0, 0,            0,   1,   0,   0,            1, 32'h2000));
    tv.push_back(mk(0, 0,          0, 0, 1, 32'hAABBCCDD, 0,   0,   0,   0,            0, 0));
    tv.push_back(mk(0, 0,          0, 0, 0, 0,            1,   0,   1,   32'h0000AABB, 0, 0));
    tv.push_back(mk(1, 32'h2003,   2, 1, 0, 0,            0,   1,   0,   0,            1, 32'h2000));
    tv.push_back(mk(0, 0,          0, 0, 1, 32'hAABBCCDD, 0,   0,   0,   0,            0, 0));
    tv.push_back(mk(0, 0,          0, 0, 0, 0,            1,   0,   1,   32'hAABBCCDD, 0, 0));
    tv.push_back(mk(1, 32'h2001,   3, 1, 0, 0,            0,   1,   0,   0,            1, 32'h2000));
    tv.push_back(mk(0, 0,          0, 0, 1, 32'hAABBCCDD, 0,   0,   0,   0,            0, 0));
    tv.push_back(mk(0, 0,          0, 0, 0, 0,            1,   0,   1,   32'hAABBCCDD, 0, 0));
    tv.push_back(mk(2, 32'h3000,   2, 1, 0, 0,            0,   2,   0,   0,            1, 32'h3000));
    tv.push_back(mk(1, 32'h4000,   2, 1, 1, 32'h11112222, 0,   1,   0,   0,            1, 32'h4000));
    tv.push_back(mk(2, 32'h5000,   2, 1, 1, 32'h33334444, 2,   2,   2,   32'h11112222, 1, 32'h5000));
    tv.push_back(mk(0, 0,          0, 0, 0, 0,            1,   0,   1,   32'h33334444, 0, 0));
    tv.push_back(mk(0, 0,          0, 0, 1, 32'h55556666, 0,   0,   0,   0,            0, 0));
    tv.push_back(mk(0, 0,          0, 0, 0, 0,            2,   0,   2,   32'h55556666, 0, 0));
    tv.push_back(mk(0, 0,          0, 0, 0, 0,            0,   0,   0,   0,            0, 0));

    do_reset("init");

    // Vector table: one vector per cycle, outputs sampled before the next edge.
    foreach (tv[k]) begin
      req = tv[k].req; addr = {N{tv[k].a}}; size = {N{tv[k].sz}};
      mgnt = tv[k].mg; rvalid = tv[k].rv; rdata = tv[k].rd; rdy = tv[k].rdy;
      #1;
      chk($sformatf("vec%0d gnt", k), 32'(gnt), 32'(tv[k].e_gnt));
      chk($sformatf("vec%0d vld", k), 32'(vld), 32'(tv[k].e_vld));
      chk($sformatf("vec%0d data", k), data, tv[k].e_data);
      chk($sformatf("vec%0d mreq", k), 32'(mreq), 32'(tv[k].e_mreq));
      chk($sformatf("vec%0d maddr", k), maddr, tv[k].e_maddr);
      @(negedge clk);
    end

    // Round robin: all four channels request, L2 always accepts.
    do_reset("rr");
    size = {N{2'b10}};
    for (int i = 0; i < N; i++) begin set_addr(i, 32'h100 * (i + 1)); cnt[i] = 0; end
    pend = 0; pend_id = 0;
    for (int k = 0; k < 40; k++) begin
      n_avail = q.size();
      req = (k < 32) ? 4'hF : 4'h0; mgnt = (k < 32); rdy = 4'hF;
      rvalid = pend; rdata = 32'hA000_0000 + k;
      if (pend) begin r.id = pend_id; r.d = rdata; q.push_back(r); end
      #1;
      if (k < 32) begin
        chk($sformatf("rr%0d gnt", k), 32'(gnt), 32'(1) << (k % 4));
        chk($sformatf("rr%0d maddr", k), maddr, 32'h100 * ((k % 4) + 1));
        for (int i = 0; i < N; i++) if (gnt == 4'(1 << i)) cnt[i]++;
      end
      if (n_avail > 0) begin
        r = q.pop_front();
        chk($sformatf("rr%0d vld", k), 32'(vld), 32'(1) << r.id);
        chk($sformatf("rr%0d data", k), data, r.d);
      end else begin
        chk($sformatf("rr%0d vld idle", k), 32'(vld), 0);
      end
      pend = (k < 32);
      pend_id = k % 4;
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) chk($sformatf("rr share ch%0d", i), 32'(cnt[i]), 8);
    chk("rr queue drained", 32'(q.size()), 0);

    // Credit exhaustion: four grants without responses, then blocked.
    do_reset("credit");
    set_addr(0, 32'h600);
    for (int k = 0; k < 4; k++) begin
      req = 4'h1; mgnt = 1; #1;
      chk($sformatf("cr%0d gnt", k), 32'(gnt), 1);
      @(negedge clk);
    end
    #1;
    chk("cr blocked mreq", 32'(mreq), 0);
    chk("cr blocked gnt", 32'(gnt), 0);
    @(negedge clk);
    rvalid = 1; rdata = 32'hCAFE0001; #1;
    chk("cr rv mreq", 32'(mreq), 0);
    @(negedge clk);
    rvalid = 0; rdy = 4'h1; #1;
    chk("cr pop vld", 32'(vld), 1);
    chk("cr pop data", data, 32'hCAFE0001);
    chk("cr pop mreq", 32'(mreq), 0);
    @(negedge clk);
    rdy = 4'h0; #1;
    chk("cr resume mreq", 32'(mreq), 1);
    chk("cr resume gnt", 32'(gnt), 1);
    @(negedge clk);

    // Head-of-line blocking: channel 2 stalls, channel 0 waits behind it.
    do_reset("hol");
    set_addr(2, 32'h2200); set_addr(0, 32'h0200);
    req = 4'h4; mgnt = 1; #1;
    chk("hol gnt2", 32'(gnt), 4);
    @(negedge clk);
    req = 4'h1; #1;
    chk("hol gnt0", 32'(gnt), 1);
    @(negedge clk);
    req = 0; mgnt = 0; rvalid = 1; rdata = 32'h22222222;
    @(negedge clk);
    rdata = 32'h00000C0C; rdy = 4'h1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("hol stall%0d vld", k), 32'(vld), 4);
      chk($sformatf("hol stall%0d data", k), data, 32'h22222222);
      @(negedge clk);
      rvalid = 0;
    end
    rdy = 4'h5; #1;
    chk("hol pop2 vld", 32'(vld), 4);
    chk("hol pop2 data", data, 32'h22222222);
    @(negedge clk);
    rdy = 4'h1; #1;
    chk("hol pop0 vld", 32'(vld), 1);
    chk("hol pop0 data", data, 32'h00000C0C);
    @(negedge clk);
    rdy = 0; #1;
    chk("hol empty vld", 32'(vld), 0);
    @(negedge clk);

    // Lock: channel 1 waits for L2; a higher-priority channel 0 must not steal it.
    do_reset("lock");
    set_addr(0, 32'h0A00); set_addr(1, 32'h1110);
    for (int k = 0; k < 3; k++) begin
      req = 4'h2; mgnt = 0; #1;
      chk($sformatf("lk wait%0d maddr", k), maddr, 32'h1110);
      chk($sformatf("lk wait%0d gnt", k), 32'(gnt), 0);
      @(negedge clk);
    end
    req = 4'h3; #1;
    chk("lk hold maddr", maddr, 32'h1110);
    @(negedge clk);
    mgnt = 1; #1;
    chk("lk gnt1", 32'(gnt), 2);
    chk("lk gnt1 maddr", maddr, 32'h1110);
    @(negedge clk);
    req = 4'h1; #1;
    chk("lk gnt0", 32'(gnt), 1);
    chk("lk gnt0 maddr", maddr, 32'h0A00);
    @(negedge clk);
    req = 4'hF; mgnt = 0;
    #2;
    rstn = 0; req = 0; #1;
    chk("mid rst gnt", 32'(gnt), 0);
    chk("mid rst vld", 32'(vld), 0);
    chk("mid rst data", data, 0);
    chk("mid rst mreq", 32'(mreq), 0);
    chk("mid rst maddr", maddr, 0);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    // Fresh credit and pointer: four grants in order 0..3, then full.
    for (int i = 0; i < N; i++) set_addr(i, 32'h40 * i);
    for (int k = 0; k < 4; k++) begin
      req = 4'hF; mgnt = 1; #1;
      chk($sformatf("post rst%0d gnt", k), 32'(gnt), 32'(1) << k);
      chk($sformatf("post rst%0d vld", k), 32'(vld), 0);
      @(negedge clk);
    end
    #1;
    chk("post rst full mreq", 32'(mreq), 0);
    @(negedge clk);
    rstn = 0; idle_in();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
